// File: rtl/booth_mult_arbiter.sv
// booth_mult_arbiter
// One sequential radix-2 Booth multiplier shared by two requesters.
// A round-robin arbiter picks a requester, and the block acknowledges it.
// One add/shift step runs per clock for WIDTH clocks. The signed product
// then appears on a shared result bus, tagged with the owner id.
//
// Handshake: reqN is a level request that is sampled only in IDLE. ackN
// pulses for one cycle after the grant edge. The requester drops reqN after
// seeing ackN unless it wants another multiply. p_valid pulses for one cycle
// when p/p_id carry a new result; p and p_id hold until the next completion.
// busy mirrors the internal state (1 = RUN), so the FSM state is observable.

module booth_mult_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0,
    input  logic [WIDTH-1:0]   m0,
    input  logic [WIDTH-1:0]   q0,
    output logic               ack0,
    input  logic               req1,
    input  logic [WIDTH-1:0]   m1,
    input  logic [WIDTH-1:0]   q1,
    output logic               ack1,
    output logic               busy,
    output logic [2*WIDTH-1:0] p,
    output logic               p_valid,
    output logic               p_id
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] m_reg;
    logic [WIDTH:0]   acc_u;     // upper part, one extra bit so -M never overflows
    logic [WIDTH-1:0] acc_l;     // lower part, starts as the multiplier
    logic             q_m1;      // the q_-1 bit appended below acc_l
    logic [CW-1:0]    cnt;
    logic             last_gnt;
    logic             owner;

    logic [WIDTH:0]     m_sext;
    logic [WIDTH:0]     u_step;
    logic [2*WIDTH-1:0] prod_next;
    logic               gnt_any;
    logic               gnt_id;

    // Booth step datapath: add/subtract M into the upper part, then shift.
    always_comb begin
        m_sext = {m_reg[WIDTH-1], m_reg};
        u_step = acc_u;
        case ({acc_l[0], q_m1})
            2'b10:   u_step = acc_u - m_sext;
            2'b01:   u_step = acc_u + m_sext;
            default: u_step = acc_u;
        endcase
        // Low 2*WIDTH bits of {U, L} after the arithmetic right shift.
        prod_next = {u_step, acc_l[WIDTH-1:1]};
    end

    // Round-robin choice: a lone request wins; on a tie, the one not served last.
    always_comb begin
        gnt_any = req0 | req1;
        gnt_id  = (req0 & req1) ? ~last_gnt : req1;
    end

    // FSM with registered outputs: arbitrate in IDLE, step WIDTH times in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            m_reg    <= '0;
            acc_u    <= '0;
            acc_l    <= '0;
            q_m1     <= 1'b0;
            cnt      <= '0;
            last_gnt <= 1'b1;
            owner    <= 1'b0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            busy     <= 1'b0;
            p        <= '0;
            p_valid  <= 1'b0;
            p_id     <= 1'b0;
        end else begin
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            p_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        m_reg    <= gnt_id ? m1 : m0;
                        acc_l    <= gnt_id ? q1 : q0;
                        acc_u    <= '0;
                        q_m1     <= 1'b0;
                        cnt      <= CW'(WIDTH);
                        last_gnt <= gnt_id;
                        owner    <= gnt_id;
                        ack0     <= ~gnt_id;
                        ack1     <= gnt_id;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc_u <= {u_step[WIDTH], u_step[WIDTH:1]};
                    acc_l <= {u_step[0], acc_l[WIDTH-1:1]};
                    q_m1  <= acc_l[0];
                    cnt   <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        p       <= prod_next;
                        p_valid <= 1'b1;
                        p_id    <= owner;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/booth_mult_arbiter.md
# booth_mult_arbiter

Sequential radix-2 Booth multiply engine shared by two requesters through a round-robin arbiter. Each requester presents signed operands with a level request. The block grants one requester, acknowledges it, and runs one Booth add/shift step per clock. It then returns the signed product on a shared result bus tagged with the requester id. It sits between the two datapath clients and the multiply resource, so one multiplier serves both.

## Interface
- WIDTH, 4, operand width in bits (signed two's complement); product is 2*WIDTH bits.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req0  input  1  requester 0 multiply request (level).
- m0  input  WIDTH  requester 0 multiplicand (signed).
- q0  input  WIDTH  requester 0 multiplier (signed).
- ack0  output  1  one-cycle pulse: requester 0 operands captured.
- req1, m1, q1, ack1  same as requester 0, for requester 1.
- busy  output  1  high while a multiply is in progress (state RUN).
- p  output  2*WIDTH  signed product of the last completed multiply.
- p_valid  output  1  one-cycle pulse: p holds a new result.
- p_id  output  1  requester that owns p (0 or 1).

## Operation
- State machine has two states.
  - IDLE: arbitrate.
  - RUN: WIDTH Booth steps.
- Arbitration happens only in IDLE, at each rising edge.
  - If only one req is high, that requester is granted.
  - If both are high, the requester other than last_gnt is granted.
  - last_gnt resets to 1, so requester 0 wins the first tie.
- On grant:
  - Capture the selected m into M and the selected q into the low WIDTH bits of the accumulator.
  - Clear the upper accumulator and the q_-1 bit.
  - Load the step counter with WIDTH.
  - Set last_gnt and the registered owner id.
  - Register ackN = 1 for one cycle.
  - Go to RUN.
- Accumulator layout: {U[WIDTH:0], L[WIDTH-1:0], q_-1}. U is WIDTH+1 bits, so negating M = -2^(WIDTH-1) does not overflow and -8*-8 = +64 is exact.
- Each RUN cycle performs one step:
  - {L[0], q_-1} = 10: U = U - sext(M).
  - {L[0], q_-1} = 01: U = U + sext(M).
  - 00 and 11: no change.
  - Then arithmetic-shift the whole accumulator right by 1 (U MSB replicated) and decrement the counter.
- On the edge performing the final step:
  - Load p with the low 2*WIDTH bits of {U, L} after the shift.
  - Set p_valid = 1 for one cycle and p_id = owner.
  - Return to IDLE.
- Requests are ignored during RUN.
  - A requester must drop req after seeing ack unless it wants another multiply.
  - A req still high on return to IDLE is treated as a new request.
- Operand inputs only matter on the grant edge. They may change freely afterwards.

## Timing
- Reset values: state IDLE, ack0 = ack1 = 0, busy = 0, p = 0, p_valid = 0, p_id = 0, last_gnt = 1, counter = 0, accumulator = 0.
- Grant edge E0 (req high, state IDLE): ackN and busy are high in the cycle after E0.
- Edges E1..E_WIDTH perform the steps.
- After E_WIDTH: p_valid = 1 and busy = 0, and the state is IDLE.
- Latency from the grant edge to p_valid is WIDTH cycles.
- Earliest next grant is edge E_WIDTH+1, so sustained throughput is one multiply per WIDTH+1 cycles.
- p and p_id hold their values until the next completion. p_valid is never high for two consecutive cycles.
- Reset mid-RUN aborts the operation:
  - No p_valid is emitted.
  - All outputs and last_gnt return to their reset values at the next edge.
- rst has priority over every other event on the same edge, including grant and completion.

## Test plan
- req0 with m0 = 3, q0 = -2 -> ack0 pulse one cycle after the grant edge; p_valid 4 cycles after grant; p = 8'hFA (-6), p_id = 0; ack1 stays 0.
- req1 with m1 = -8, q1 = -8 -> p = 8'h40 (+64), p_id = 1. Also m = -8, q = 7 -> p = 8'hC8 (-56); m = 7, q = 7 -> p = 8'h31 (+49).
- Out of reset, req0 and req1 raised on the same edge (0: 2*3, 1: -1*5) -> requester 0 served first (p = 6, p_id = 0); requester 1 granted on the edge after that p_valid (p = 8'hFB, p_id = 1).
- req0 and req1 held high continuously for 6 multiplies -> p_id sequence 0,1,0,1,0,1; successive p_valid pulses exactly 5 cycles apart; ack pulses alternate.
- rst asserted for one cycle during the second RUN cycle of a req0 multiply -> no p_valid; busy = 0 and p = 0 after the reset edge; a following simultaneous request is granted to requester 0.
- Operands changed on every cycle after ack0 -> result equals the product of the operands present at the grant edge.
